// File: rtl/qos_pkg.sv
// Shared QoS-path definitions: data/VC widths and the per-VC pause state.
package qos_pkg;
  localparam int DATA_W  = 4;
  localparam int NUM_VC  = 4;
  localparam int VC_ID_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } vc_state_e;
endpackage

// File: rtl/vc_fifo_bank_fifo.sv
// Single-VC FIFO: storage, occupancy count, RUN/PAUSED hysteresis and
// overflow/underflow strobes. Head word is presented combinationally.
module vc_fifo
  import qos_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HI_THR = 3,
  parameter int LO_THR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              pop_ok,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output vc_state_e         state,
  output logic              cont,
  output logic              ovf,
  output logic              udf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push_ok;
  vc_state_e         state_nxt;
  logic              leave;

  // A full FIFO still takes a push when the same cycle frees a slot by popping;
  // an empty FIFO never forwards a same-cycle push to the pop side.
  assign pop_ok    = pop && (count != '0);
  assign push_ok   = push && ((count < CNT_W'(DEPTH)) || pop_ok);
  assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      cont   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
      ovf   <= push && !push_ok;
      udf   <= pop && !pop_ok;
      cont  <= leave;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Hysteresis on the post-update count; the band between thresholds holds state.
  always_comb begin
    state_nxt = state;
    leave     = 1'b0;
    case (state)
      RUN:    if (count_nxt >= CNT_W'(HI_THR)) state_nxt = PAUSED;
      PAUSED: if (count_nxt <= CNT_W'(LO_THR)) begin
                state_nxt = RUN;
                leave     = 1'b1;
              end
      default: state_nxt = RUN;
    endcase
  end
endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC input FIFOs for the QoS path: push/pop demux by VC id,
// registered head-word output and per-VC status packing.
module vc_fifo_bank
  import qos_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HI_THR = 3,
  parameter int LO_THR = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [VC_ID_W-1:0] push_vc,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  input  logic [VC_ID_W-1:0] pop_vc,
  output logic [DATA_W-1:0]  pop_data,
  output logic               pop_valid,
  output logic [NUM_VC-1:0]  sEmpty,
  output logic [NUM_VC-1:0]  sFull,
  output logic [NUM_VC-1:0]  sPause,
  output logic [NUM_VC-1:0]  sContinue,
  output logic [NUM_VC-1:0]  ovf,
  output logic [NUM_VC-1:0]  udf
);
  // Command semantics: push and pop are one-cycle requests with no ready
  // handshake. Acceptance is decided internally; a refused request is reported
  // one cycle later on ovf/udf, an accepted pop on pop_valid with pop_data.
  logic [NUM_VC-1:0] push_sel, pop_sel, pop_acc;
  logic [DATA_W-1:0] head [NUM_VC];
  vc_state_e         vc_state [NUM_VC];
  logic [DATA_W-1:0] head_sel;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    // Out-of-range VC ids match no lane, so they are silently dropped.
    assign push_sel[i] = push && (push_vc == VC_ID_W'(i));
    assign pop_sel[i]  = pop && (pop_vc == VC_ID_W'(i));

    vc_fifo #(
      .DEPTH (DEPTH),
      .HI_THR(HI_THR),
      .LO_THR(LO_THR)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_sel[i]),
      .push_data(push_data),
      .pop      (pop_sel[i]),
      .pop_ok   (pop_acc[i]),
      .head     (head[i]),
      .empty    (sEmpty[i]),
      .full     (sFull[i]),
      .state    (vc_state[i]),
      .cont     (sContinue[i]),
      .ovf      (ovf[i]),
      .udf      (udf[i])
    );

    assign sPause[i] = (vc_state[i] == PAUSED);
  end

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (pop_acc[i]) head_sel = head[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      if (|pop_acc) pop_data <= head_sel;
      pop_valid <= |pop_acc;
    end
  end
endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank: directed vector table, a reset
// mid-burst sequence and randomized traffic against a queue-based model.
module tb_vc_fifo_bank;
  import qos_pkg::*;

  localparam int DEPTH  = 4;
  localparam int HI_THR = 3;
  localparam int LO_THR = 1;
  localparam int NVEC   = 38;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               push, pop;
  logic [VC_ID_W-1:0] push_vc, pop_vc;
  logic [DATA_W-1:0]  push_data;
  logic [DATA_W-1:0]  pop_data;
  logic               pop_valid;
  logic [NUM_VC-1:0]  sEmpty, sFull, sPause, sContinue, ovf, udf;

  vc_fifo_bank #(.DEPTH(DEPTH), .HI_THR(HI_THR), .LO_THR(LO_THR)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_vc  (push_vc),
    .push_data(push_data),
    .pop      (pop),
    .pop_vc   (pop_vc),
    .pop_data (pop_data),
    .pop_valid(pop_valid),
    .sEmpty   (sEmpty),
    .sFull    (sFull),
    .sPause   (sPause),
    .sContinue(sContinue),
    .ovf      (ovf),
    .udf      (udf)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [NUM_VC][$];
  bit                m_paused [NUM_VC];
  logic              m_val;
  logic [DATA_W-1:0] m_data;
  logic [NUM_VC-1:0] m_empty, m_full, m_pause, m_cont, m_ovf, m_udf;
  logic [DATA_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit pacc, uacc;
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        mq[v].delete();
        m_paused[v] = 0;
      end
      exp_q.delete();
      m_val = 0; m_data = '0;
      m_empty = '1; m_full = '0; m_pause = '0; m_cont = '0; m_ovf = '0; m_udf = '0;
    end else begin
      m_ovf = '0; m_udf = '0; m_cont = '0;
      pacc = pop && (mq[pop_vc].size() > 0);
      uacc = push && ((mq[push_vc].size() < DEPTH) || (pacc && pop_vc == push_vc));
      if (pop && !pacc)  m_udf[pop_vc]  = 1'b1;
      if (push && !uacc) m_ovf[push_vc] = 1'b1;
      m_val = pacc;
      if (pacc) begin
        m_data = mq[pop_vc].pop_front();
        exp_q.push_back(m_data);
      end
      if (uacc) mq[push_vc].push_back(push_data);
      for (int v = 0; v < NUM_VC; v++) begin
        int n;
        n = mq[v].size();
        m_empty[v] = (n == 0);
        m_full[v]  = (n == DEPTH);
        if (!m_paused[v] && n >= HI_THR) m_paused[v] = 1;
        else if (m_paused[v] && n <= LO_THR) begin
          m_paused[v] = 0;
          m_cont[v]   = 1'b1;
        end
        m_pause[v] = m_paused[v];
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic pu, input logic [VC_ID_W-1:0] pv,
                       input logic [DATA_W-1:0] pd, input logic po, input logic [VC_ID_W-1:0] ov);
    reset = r; push = pu; push_vc = pv; push_data = pd; pop = po; pop_vc = ov;
  endtask

  // One clock: model advances on the edge, DUT sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("pop_valid", pop_valid, m_val);
    check("pop_data", pop_data, m_data);
    check("sEmpty", sEmpty, m_empty);
    check("sFull", sFull, m_full);
    check("sPause", sPause, m_pause);
    check("sContinue", sContinue, m_cont);
    check("ovf", ovf, m_ovf);
    check("udf", udf, m_udf);
    if (pop_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", 1, 0);
      else check("sb_pop", pop_data, exp_q.pop_front());
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic r, pu; logic [1:0] pv; logic [3:0] pd; logic po; logic [1:0] ov;
    logic e_val; logic [3:0] e_data, e_empty, e_full, e_pause, e_cont, e_ovf, e_udf;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(logic r, logic pu, logic [1:0] pv, logic [3:0] pd, logic po,
                              logic [1:0] ov, logic ev, logic [3:0] ed, logic [3:0] ee,
                              logic [3:0] ef, logic [3:0] ep, logic [3:0] ec,
                              logic [3:0] eo, logic [3:0] eu);
    vec_t t;
    t.r = r; t.pu = pu; t.pv = pv; t.pd = pd; t.po = po; t.ov = ov;
    t.e_val = ev; t.e_data = ed; t.e_empty = ee; t.e_full = ef;
    t.e_pause = ep; t.e_cont = ec; t.e_ovf = eo; t.e_udf = eu;
    return t;
  endfunction

  initial begin
    //               r  pu pv pd   po ov  val data  empty full pause cont ovf  udf
    vecs[0]  = mk(1, 0, 0, 0,   0, 0,  0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[1]  = mk(0, 0, 0, 0,   0, 0,  0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // VC2 fill then drain in order
    vecs[2]  = mk(0, 1, 2, 1,   0, 0,  0, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[3]  = mk(0, 1, 2, 2,   0, 0,  0, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[4]  = mk(0, 1, 2, 3,   0, 0,  0, 4'h0, 4'hB, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[5]  = mk(0, 1, 2, 4,   0, 0,  0, 4'h0, 4'hB, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[6]  = mk(0, 0, 0, 0,   1, 2,  1, 4'h1, 4'hB, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[7]  = mk(0, 0, 0, 0,   1, 2,  1, 4'h2, 4'hB, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
    vecs[8]  = mk(0, 0, 0, 0,   1, 2,  1, 4'h3, 4'hB, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
    vecs[9]  = mk(0, 0, 0, 0,   1, 2,  1, 4'h4, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // VC1 pause hysteresis
    vecs[10] = mk(0, 1, 1, 5,   0, 0,  0, 4'h4, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[11] = mk(0, 1, 1, 6,   0, 0,  0, 4'h4, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[12] = mk(0, 1, 1, 7,   0, 0,  0, 4'h4, 4'hD, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    vecs[13] = mk(0, 0, 0, 0,   1, 1,  1, 4'h5, 4'hD, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    vecs[14] = mk(0, 0, 0, 0,   1, 1,  1, 4'h6, 4'hD, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
    vecs[15] = mk(0, 0, 0, 0,   1, 1,  1, 4'h7, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // VC0 full: push+pop same cycle, then push alone overflows
    vecs[16] = mk(0, 1, 0, 8,   0, 0,  0, 4'h7, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[17] = mk(0, 1, 0, 9,   0, 0,  0, 4'h7, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[18] = mk(0, 1, 0, 10,  0, 0,  0, 4'h7, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[19] = mk(0, 1, 0, 11,  0, 0,  0, 4'h7, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[20] = mk(0, 1, 0, 12,  1, 0,  1, 4'h8, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[21] = mk(0, 1, 0, 13,  0, 0,  0, 4'h8, 4'hE, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0);
    vecs[22] = mk(0, 0, 0, 0,   0, 0,  0, 4'h8, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[23] = mk(0, 0, 0, 0,   1, 0,  1, 4'h9, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[24] = mk(0, 0, 0, 0,   1, 0,  1, 4'hA, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    vecs[25] = mk(0, 0, 0, 0,   1, 0,  1, 4'hB, 4'hE, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    vecs[26] = mk(0, 0, 0, 0,   1, 0,  1, 4'hC, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // VC3 underflow, and push+pop while empty (no bypass)
    vecs[27] = mk(0, 0, 0, 0,   1, 3,  0, 4'hC, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8);
    vecs[28] = mk(0, 1, 3, 5,   1, 3,  0, 4'hC, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8);
    vecs[29] = mk(0, 0, 0, 0,   1, 3,  1, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // partial fill of every VC, then reset mid-burst
    vecs[30] = mk(0, 1, 0, 1,   0, 0,  0, 4'h5, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[31] = mk(0, 1, 1, 2,   0, 0,  0, 4'h5, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[32] = mk(0, 1, 2, 3,   0, 0,  0, 4'h5, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[33] = mk(0, 1, 3, 4,   0, 0,  0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[34] = mk(0, 1, 1, 6,   0, 0,  0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[35] = mk(0, 1, 1, 7,   0, 0,  0, 4'h5, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    vecs[36] = mk(1, 1, 2, 9,   1, 1,  0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[37] = mk(0, 0, 0, 0,   0, 0,  0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
  end

  // ---------------- test sequence ----------------
  initial begin
    int push_pct;
    drive(1, 0, 0, 0, 0, 0);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].r, vecs[i].pu, vecs[i].pv, vecs[i].pd, vecs[i].po, vecs[i].ov);
      step();
      check($sformatf("vec%0d_pop_valid", i), pop_valid, vecs[i].e_val);
      check($sformatf("vec%0d_pop_data", i), pop_data, vecs[i].e_data);
      check($sformatf("vec%0d_sEmpty", i), sEmpty, vecs[i].e_empty);
      check($sformatf("vec%0d_sFull", i), sFull, vecs[i].e_full);
      check($sformatf("vec%0d_sPause", i), sPause, vecs[i].e_pause);
      check($sformatf("vec%0d_sContinue", i), sContinue, vecs[i].e_cont);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].e_ovf);
      check($sformatf("vec%0d_udf", i), udf, vecs[i].e_udf);
    end

    // Same-VC push+pop on a full FIFO: contents must rotate with no overflow.
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, 1, 2, DATA_W'(k + 3), 0, 0);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 2, DATA_W'(k + 9), 1, 2);
      step();
      check("rotate_no_ovf", ovf, 4'h0);
      check("rotate_full", sFull[2], 1'b1);
    end

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int c = 0; c < 1200; c++) begin
      push_pct = ((c / 60) % 2 == 0) ? 75 : 30;
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < push_pct),
            VC_ID_W'($urandom_range(0, NUM_VC - 1)),
            DATA_W'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < (100 - push_pct)),
            VC_ID_W'($urandom_range(0, NUM_VC - 1)));
      step();
    end

    drive(0, 0, 0, 0, 0, 0);
    step();
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
